ddr3_init_sequencer: RTL
========================

Name: ddr3_init_sequencer

Overview:
Power-up initialisation controller for the SSTL18 DDR3 pad interface: it drives the command, control, reset and DQ-direction inputs of the pad block through the JEDEC DDR3 reset/CKE/MRS/ZQCL sequence, then asserts init_done_o. It sits between the clock/reset block and the DDR3 command scheduler. The scheduler takes ownership of the pads only after init_done_o is high.

Parameters:
CNT_W, 20, timer width. Every timing parameter must be ≥1 and <2^CNT_W.
T_RESET_CYC, 200000, cycles resetbar_o is held low.
T_CKE_CYC, 500000, cycles cke_o stays low after resetbar_o rises.
T_XPR_CYC, 80, cycles from cke_o rising to the first MRS.
T_MRD_CYC, 4, cycles between consecutive MRS commands.
T_MOD_CYC, 12, cycles from MR0 to the next command or to done.
T_ZQINIT_CYC, 512, cycles from ZQCL to done.
MR0_VAL/MR1_VAL/MR2_VAL/MR3_VAL, 13'h0000, mode-register payloads driven on a_o.

Ports:
clk_i  in  1  controller clock
rst_i  in  1  synchronous, active-high reset
restart_i  in  1  re-run the sequence; honoured only in DONE
cke_o  out  1  to pad cke_i
csbar_o, rasbar_o, casbar_o, webar_o  out  1 each  command to pads
ba_o  out  3  bank address / MR index
a_o  out  13  address / MR payload
odt_o  out  1  to pad odt_i
resetbar_o  out  1  to pad resetbar_i
ts_o  out  1  DQ/DQS/DM driver enable (to ts_i)
ri_o  out  1  DQ receiver enable (to ri_i)
init_done_o  out  1  sequence complete

Behaviour:
- All outputs are registered. Reset values: resetbar_o=0, cke_o=0, csbar/rasbar/casbar/webar=1 (DES), ba_o=0, a_o=0, odt_o=0, ts_o=0, ri_o=0, init_done_o=0. State resets to RST_LOW.
- Cycle 0 is the first rising edge with rst_i=0. Reset mid-sequence aborts the sequence immediately and restarts it from cycle 0.
- States, in order:
  - RST_LOW: T_RESET_CYC cycles.
  - CKE_LOW: resetbar_o=1, T_CKE_CYC cycles.
  - XPR: cke_o=1, T_XPR_CYC cycles.
  - MRS2, MRS3, MRS1, MRS0: each is a 1-cycle command followed by DES.
  - ZQCL: 1-cycle command followed by DES.
  - DONE.
- Spacing: command-to-command distance is T_MRD_CYC between MRS commands. MR0 to ZQCL is T_MOD_CYC. ZQCL to DONE is T_ZQINIT_CYC.
- Encodings:
  - MRS: cs/ras/cas/we=0000, ba_o=MR index, a_o=MRn_VAL.
  - ZQCL: cs/ras/cas/we=0110, a_o[10]=1, other a_o bits=0, ba_o=0.
  - Every other cycle is DES with ba_o=0 and a_o=0.
- ts_o, ri_o and odt_o stay 0 throughout; downstream logic takes them over after DONE.
- DONE: init_done_o=1, cke_o=1, resetbar_o=1, DES driven.
  - restart_i=1 in DONE: next cycle enters RST_LOW, with init_done_o=0, resetbar_o=0 and cke_o=0.
  - restart_i in any other state is ignored.
- Timer: loads (duration−1) on state entry and down-counts; the state advances on terminal count 0. A duration of 1 therefore means one cycle, and T_MRD_CYC=1 gives back-to-back MRS commands.

Optional Feature:
DDR3_INIT_ZQCL_EN.
- Defined: ZQCL is issued T_MOD_CYC after MR0, and DONE follows T_ZQINIT_CYC later.
- Undefined: no ZQCL state; DONE is entered T_MOD_CYC after MR0, and T_ZQINIT_CYC is unused.

Decomposition:
- Package ddr3_init_pkg holds:
  - the state enum;
  - 4-bit command encodings DES, MRS and ZQCL;
  - MR index constants MR0..MR3 (3'd0..3'd3);
  - the A10 bit position.
- One sub-module, ddr3_init_timer: CNT_W down-counter with load, load value and expired output.

Test Plan:
All scenarios use T_RESET=4, T_CKE=5, T_XPR=3, T_MRD=4, T_MOD=6, T_ZQINIT=8.
1. Nominal run, ZQCL_EN defined -> resetbar_o rises at cycle 4; cke_o at 9; MRS with ba=2,3,1,0 at cycles 12,16,20,24; ZQCL with a_o=13'h0400 at 30; init_done_o at 38.
2. ZQCL_EN undefined -> same MRS timing, no ZQCL, init_done_o at 30.
3. Distinct MRn_VAL (13'h1111,13'h0222,13'h0033,13'h0004) -> a_o carries each value only on its MRS cycle; DES with a_o=0 elsewhere.
4. rst_i pulsed at cycle 18 -> outputs return to reset values next edge; a full sequence restarts and init_done_o rises 38 cycles after release.
5. restart_i at cycle 20 (ignored) then at cycle 40 -> first pulse has no effect; the second drops init_done_o and resetbar_o on the next cycle, and a repeat sequence completes.
6. T_MRD=1 -> four consecutive MRS cycles with no DES between them.

Source files
------------

// File: rtl/ddr3_init_pkg.sv
// rtl/ddr3_init_pkg.sv - states, command encodings and MR indices for the DDR3 init sequencer
package ddr3_init_pkg;

  typedef enum logic [3:0] {
    ST_RST_LOW,
    ST_CKE_LOW,
    ST_XPR,
    ST_MRS2,
    ST_MRS3,
    ST_MRS1,
    ST_MRS0,
    ST_ZQCL,
    ST_DONE
  } state_t;

  // {csbar, rasbar, casbar, webar}
  localparam logic [3:0] CMD_DES  = 4'b1111;
  localparam logic [3:0] CMD_MRS  = 4'b0000;
  localparam logic [3:0] CMD_ZQCL = 4'b0110;

  localparam logic [2:0] MR0 = 3'd0;
  localparam logic [2:0] MR1 = 3'd1;
  localparam logic [2:0] MR2 = 3'd2;
  localparam logic [2:0] MR3 = 3'd3;

  localparam int A10_BIT = 10;

endpackage

// File: rtl/ddr3_init_timer.sv
// rtl/ddr3_init_timer.sv - loadable down-counter flagging terminal count zero
module ddr3_init_timer #(
  parameter int unsigned CNT_W = 20
) (
  input  logic             i_clk,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_expired
);

  logic [CNT_W-1:0] r_cnt;

  // Load wins over counting; the count parks at zero until the next load.
  always_ff @(posedge i_clk) begin
    if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/ddr3_init_sequencer.sv
// rtl/ddr3_init_sequencer.sv - DDR3 reset/CKE/MRS sequencer; DDR3_INIT_ZQCL_EN adds the ZQCL step
module ddr3_init_sequencer #(
  parameter int unsigned CNT_W        = 20,
  parameter int unsigned T_RESET_CYC  = 200000,
  parameter int unsigned T_CKE_CYC    = 500000,
  parameter int unsigned T_XPR_CYC    = 80,
  parameter int unsigned T_MRD_CYC    = 4,
  parameter int unsigned T_MOD_CYC    = 12,
  parameter int unsigned T_ZQINIT_CYC = 512,
  parameter logic [12:0] MR0_VAL      = 13'h0000,
  parameter logic [12:0] MR1_VAL      = 13'h0000,
  parameter logic [12:0] MR2_VAL      = 13'h0000,
  parameter logic [12:0] MR3_VAL      = 13'h0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        restart_i,
  output logic        cke_o,
  output logic        csbar_o,
  output logic        rasbar_o,
  output logic        casbar_o,
  output logic        webar_o,
  output logic [2:0]  ba_o,
  output logic [12:0] a_o,
  output logic        odt_o,
  output logic        resetbar_o,
  output logic        ts_o,
  output logic        ri_o,
  output logic        init_done_o
);

  import ddr3_init_pkg::*;

  state_t           r_state;
  state_t           w_next_state;
  logic             w_enter;
  logic             w_expired;
  logic             w_load;
  logic [CNT_W-1:0] w_dur;
  logic [CNT_W-1:0] w_load_val;

  logic [3:0]  w_cmd;
  logic [2:0]  w_ba;
  logic [12:0] w_a;
  logic        w_resetbar;
  logic        w_cke;
  logic        w_done;

  logic [3:0]  r_cmd;
  logic [2:0]  r_ba;
  logic [12:0] r_a;
  logic        r_resetbar;
  logic        r_cke;
  logic        r_done;

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_RST_LOW;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state, plus the pad values that state will present; commands fire only on entry.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_RST_LOW: if (w_expired) w_next_state = ST_CKE_LOW;
      ST_CKE_LOW: if (w_expired) w_next_state = ST_XPR;
      ST_XPR:     if (w_expired) w_next_state = ST_MRS2;
      ST_MRS2:    if (w_expired) w_next_state = ST_MRS3;
      ST_MRS3:    if (w_expired) w_next_state = ST_MRS1;
      ST_MRS1:    if (w_expired) w_next_state = ST_MRS0;
`ifdef DDR3_INIT_ZQCL_EN
      ST_MRS0:    if (w_expired) w_next_state = ST_ZQCL;
`else
      ST_MRS0:    if (w_expired) w_next_state = ST_DONE;
`endif
      ST_ZQCL:    if (w_expired) w_next_state = ST_DONE;
      ST_DONE:    if (restart_i) w_next_state = ST_RST_LOW;
      default:    w_next_state = ST_RST_LOW;
    endcase

    w_enter    = (w_next_state != r_state);
    w_resetbar = (w_next_state != ST_RST_LOW);
    w_cke      = (w_next_state != ST_RST_LOW) && (w_next_state != ST_CKE_LOW);
    w_done     = (w_next_state == ST_DONE);

    w_cmd = CMD_DES;
    w_ba  = '0;
    w_a   = '0;
    if (w_enter) begin
      case (w_next_state)
        ST_MRS2: begin w_cmd = CMD_MRS; w_ba = MR2; w_a = MR2_VAL; end
        ST_MRS3: begin w_cmd = CMD_MRS; w_ba = MR3; w_a = MR3_VAL; end
        ST_MRS1: begin w_cmd = CMD_MRS; w_ba = MR1; w_a = MR1_VAL; end
        ST_MRS0: begin w_cmd = CMD_MRS; w_ba = MR0; w_a = MR0_VAL; end
        ST_ZQCL: begin w_cmd = CMD_ZQCL; w_a[A10_BIT] = 1'b1; end
        default: ;
      endcase
    end
  end

  // Dwell time of the state being entered; MR0 dwell is tMOD because the next command follows it.
  always_comb begin
    w_dur = CNT_W'(1);
    case (w_next_state)
      ST_RST_LOW: w_dur = CNT_W'(T_RESET_CYC);
      ST_CKE_LOW: w_dur = CNT_W'(T_CKE_CYC);
      ST_XPR:     w_dur = CNT_W'(T_XPR_CYC);
      ST_MRS2:    w_dur = CNT_W'(T_MRD_CYC);
      ST_MRS3:    w_dur = CNT_W'(T_MRD_CYC);
      ST_MRS1:    w_dur = CNT_W'(T_MRD_CYC);
      ST_MRS0:    w_dur = CNT_W'(T_MOD_CYC);
      ST_ZQCL:    w_dur = CNT_W'(T_ZQINIT_CYC);
      default:    w_dur = CNT_W'(1);
    endcase
  end

  // The reset edge is not a sequence cycle, so it preloads the full tRESET rather than tRESET-1.
  assign w_load     = rst_i | w_enter;
  assign w_load_val = rst_i ? CNT_W'(T_RESET_CYC) : (w_dur - CNT_W'(1));

  ddr3_init_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .i_clk      (clk_i),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_expired  (w_expired)
  );

  // Pad-facing output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cmd      <= CMD_DES;
      r_ba       <= '0;
      r_a        <= '0;
      r_resetbar <= 1'b0;
      r_cke      <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_cmd      <= w_cmd;
      r_ba       <= w_ba;
      r_a        <= w_a;
      r_resetbar <= w_resetbar;
      r_cke      <= w_cke;
      r_done     <= w_done;
    end
  end

  assign csbar_o     = r_cmd[3];
  assign rasbar_o    = r_cmd[2];
  assign casbar_o    = r_cmd[1];
  assign webar_o     = r_cmd[0];
  assign ba_o        = r_ba;
  assign a_o         = r_a;
  assign resetbar_o  = r_resetbar;
  assign cke_o       = r_cke;
  assign init_done_o = r_done;

  // DQ drivers, receivers and ODT stay off; the scheduler takes them over after init.
  assign odt_o = 1'b0;
  assign ts_o  = 1'b0;
  assign ri_o  = 1'b0;

endmodule
